// File: rtl/lpc_postcode_fifo.sv
// lpc_postcode_fifo
// Captures host I/O writes to the POST-code port into a small show-ahead FIFO
// and presents them on a valid/ready stream. Also keeps the most recent code,
// a sticky overflow flag and a saturating drop counter.
// Optional build macro: LPC_POSTCODE_TIMESTAMP_EN adds a free-running 16-bit
// cycle counter, stores its value with each entry and exposes code_time_o.
// DEPTH must equal 2**PTR_W so that pointers wrap naturally.
module lpc_postcode_fifo #(
    parameter logic [15:0] PORT_ADDR = 16'h0080,
    parameter int          DEPTH     = 16,
    parameter int          PTR_W     = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [15:0]      periph_addr_i,
    input  logic [7:0]       periph_data_i,
    input  logic             periph_wr_strobe_i,
    input  logic             periph_memory_cycle_i,
    output logic [7:0]       code_data_o,
    output logic             code_valid_o,
    input  logic             code_ready_i,
    output logic [PTR_W:0]   fifo_level_o,
    output logic [7:0]       last_code_o,
    output logic             overflow_o,
    output logic [7:0]       drop_count_o,
`ifdef LPC_POSTCODE_TIMESTAMP_EN
    output logic [15:0]      code_time_o,
`endif
    input  logic             overflow_clr_i
);

    localparam logic [PTR_W:0]   FULL_LVL = DEPTH[PTR_W:0];
    localparam logic [PTR_W:0]   LVL_ONE  = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   level;

    logic hit;
    logic empty;
    logic full;
    logic pop;
    logic push;
    logic drop;

    assign hit   = periph_wr_strobe_i & ~periph_memory_cycle_i &
                   (periph_addr_i == PORT_ADDR);
    assign empty = (level == '0);
    assign full  = (level == FULL_LVL);
    assign pop   = ~empty & code_ready_i;
    // A full FIFO still accepts a code when the head leaves in the same cycle.
    assign push  = hit & (~full | pop);
    assign drop  = hit & full & ~pop;

    assign code_valid_o = ~empty;
    assign code_data_o  = empty ? 8'h00 : mem[rd_ptr];
    assign fifo_level_o = level;

    // Storage array; contents need no reset because level gates visibility.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push) begin
            mem[wr_ptr] <= periph_data_i;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                level <= level + LVL_ONE;
            end else if (pop && !push) begin
                level <= level - LVL_ONE;
            end
        end
    end

    // Last code seen, updated on every hit including dropped ones.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_code_o <= 8'h00;
        end else if (hit) begin
            last_code_o <= periph_data_i;
        end
    end

    // Overflow status; a drop in the same cycle as a clear restarts the count at 1.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            overflow_o   <= 1'b0;
            drop_count_o <= 8'h00;
        end else if (drop) begin
            overflow_o <= 1'b1;
            if (overflow_clr_i) begin
                drop_count_o <= 8'h01;
            end else if (drop_count_o != 8'hFF) begin
                drop_count_o <= drop_count_o + 8'h01;
            end
        end else if (overflow_clr_i) begin
            overflow_o   <= 1'b0;
            drop_count_o <= 8'h00;
        end
    end

`ifdef LPC_POSTCODE_TIMESTAMP_EN
    logic [15:0] ts_cnt;
    logic [15:0] ts_mem [DEPTH];

    assign code_time_o = empty ? 16'h0000 : ts_mem[rd_ptr];

    // Free-running cycle counter used as the capture timestamp.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ts_cnt <= 16'h0000;
        end else begin
            ts_cnt <= ts_cnt + 16'h0001;
        end
    end

    // Timestamp storage written alongside the code data.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push) begin
            ts_mem[wr_ptr] <= ts_cnt;
        end
    end
`endif

endmodule
